// File: rtl/ram_ctrl.sv
// Request/response controller in front of a dual-read, single-write RAM.
// Supports read-pair, write, copy and clear-all operations with range checking.
module ram_ctrl #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 15
) (
  input  logic             ramctrlCLK,
  input  logic             ramctrlRST,
  input  logic             ramctrlREQV,
  output logic             ramctrlREQR,
  input  logic [1:0]       ramctrlOP,
  input  logic [3:0]       ramctrlA,
  input  logic [3:0]       ramctrlB,
  input  logic [WIDTH-1:0] ramctrlD,
  output logic             ramctrlRSPV,
  output logic [WIDTH-1:0] ramctrlRSP1,
  output logic [WIDTH-1:0] ramctrlRSP2,
  output logic             ramctrlERR,
  output logic [3:0]       ramctrlRA1,
  output logic [3:0]       ramctrlRA2,
  output logic [3:0]       ramctrlWA,
  output logic [WIDTH-1:0] ramctrlWD,
  output logic             ramctrlWE,
  input  logic [WIDTH-1:0] ramctrlRD1,
  input  logic [WIDTH-1:0] ramctrlRD2
);

  typedef enum logic [2:0] {
    IDLE, READ, WRITE, COPY_RD, COPY_WR, CLEAR, DONE
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;
  localparam logic [3:0] LAST_ADDR = 4'(DEPTH - 1);

  state_t state, state_nxt;

  logic [1:0]       op_p0;
  logic [3:0]       a_p0;
  logic [3:0]       b_p0;
  logic [WIDTH-1:0] d_p0;
  logic [WIDTH-1:0] hold_p1;
  logic [3:0]       cnt;
  logic             err_q;
  logic             we_c;
  logic             accept;
  logic             a_bad, b_bad, req_err;

  assign ramctrlREQR = (state == IDLE);
  assign ramctrlRSPV = (state == DONE);
  assign ramctrlERR  = ramctrlRSPV & err_q;
  assign accept      = ramctrlREQV & ramctrlREQR;

  assign a_bad   = ({1'b0, ramctrlA} >= 5'(DEPTH));
  assign b_bad   = ({1'b0, ramctrlB} >= 5'(DEPTH));
  assign req_err = ((ramctrlOP != OP_CLEAR) & a_bad) |
                   (((ramctrlOP == OP_READ) | (ramctrlOP == OP_COPY)) & b_bad);

  // An edge with reset high must never write, so the strobe is gated combinationally.
  assign ramctrlWE = we_c & ~ramctrlRST;

  always_ff @(posedge ramctrlCLK) begin
    if (ramctrlRST) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    we_c       = 1'b0;
    ramctrlRA1 = 4'd0;
    ramctrlRA2 = 4'd0;
    ramctrlWA  = 4'd0;
    ramctrlWD  = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err) state_nxt = DONE;
          else begin
            case (ramctrlOP)
              OP_READ:  state_nxt = READ;
              OP_WRITE: state_nxt = WRITE;
              OP_COPY:  state_nxt = COPY_RD;
              default:  state_nxt = CLEAR;
            endcase
          end
        end
      end
      READ: begin
        ramctrlRA1 = a_p0;
        ramctrlRA2 = b_p0;
        state_nxt  = DONE;
      end
      WRITE: begin
        ramctrlWA = a_p0;
        ramctrlWD = d_p0;
        we_c      = 1'b1;
        state_nxt = DONE;
      end
      COPY_RD: begin
        ramctrlRA1 = b_p0;
        state_nxt  = COPY_WR;
      end
      COPY_WR: begin
        ramctrlWA = a_p0;
        ramctrlWD = hold_p1;
        we_c      = 1'b1;
        state_nxt = DONE;
      end
      CLEAR: begin
        ramctrlWA = cnt;
        we_c      = 1'b1;
        if (cnt == LAST_ADDR) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: request fields captured on acceptance
  always_ff @(posedge ramctrlCLK) begin
    if (accept) begin
      op_p0 <= ramctrlOP;
      a_p0  <= ramctrlA;
      b_p0  <= ramctrlB;
      d_p0  <= ramctrlD;
    end
  end

  // Stage p1: hold register, clear counter and response registers
  always_ff @(posedge ramctrlCLK) begin
    if (ramctrlRST) begin
      cnt         <= 4'd0;
      hold_p1     <= '0;
      err_q       <= 1'b0;
      ramctrlRSP1 <= '0;
      ramctrlRSP2 <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 4'd0;
          if (accept) begin
            err_q <= req_err;
            if (req_err) begin
              ramctrlRSP1 <= '0;
              ramctrlRSP2 <= '0;
            end
          end
        end
        READ: begin
          ramctrlRSP1 <= ramctrlRD1;
          ramctrlRSP2 <= ramctrlRD2;
        end
        WRITE: begin
          ramctrlRSP1 <= d_p0;
          ramctrlRSP2 <= '0;
        end
        COPY_RD: hold_p1 <= ramctrlRD1;
        COPY_WR: begin
          ramctrlRSP1 <= hold_p1;
          ramctrlRSP2 <= '0;
        end
        CLEAR: begin
          if (cnt == LAST_ADDR) begin
            cnt         <= 4'd0;
            ramctrlRSP1 <= '0;
            ramctrlRSP2 <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl: a behavioural memory model predicts responses
// and RAM writes; monitors compare them whenever the DUT presents RSPV or WE.
module tb_ram_ctrl;
  localparam int DEPTH = 10;
  localparam int WIDTH = 15;

  typedef struct {
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] r2;
    logic             e;
    int               cyc;
  } rsp_t;

  typedef struct {
    logic [3:0]       a;
    logic [WIDTH-1:0] d;
    int               cyc;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             reqv = 1'b0;
  logic             reqr;
  logic [1:0]       op = 2'b00;
  logic [3:0]       a = 4'd0;
  logic [3:0]       b = 4'd0;
  logic [WIDTH-1:0] d = '0;
  logic             rspv, err, we;
  logic [WIDTH-1:0] rsp1, rsp2, wd, rd1, rd2;
  logic [3:0]       ra1, ra2, wa;

  logic [WIDTH-1:0] ram   [16];
  logic [WIDTH-1:0] model [DEPTH];

  rsp_t rspq[$];
  wr_t  wq[$];
  rsp_t mon_r;
  wr_t  mon_w;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int prev_acc = 0;
  int prev_lat = 0;
  bit prev_valid = 1'b0;

  ram_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .ramctrlCLK(clk), .ramctrlRST(rst), .ramctrlREQV(reqv), .ramctrlREQR(reqr),
    .ramctrlOP(op), .ramctrlA(a), .ramctrlB(b), .ramctrlD(d),
    .ramctrlRSPV(rspv), .ramctrlRSP1(rsp1), .ramctrlRSP2(rsp2), .ramctrlERR(err),
    .ramctrlRA1(ra1), .ramctrlRA2(ra2), .ramctrlWA(wa), .ramctrlWD(wd), .ramctrlWE(we),
    .ramctrlRD1(rd1), .ramctrlRD2(rd2)
  );

  always #5 clk = ~clk;

  assign rd1 = ram[ra1];
  assign rd2 = ram[ra2];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (we) ram[wa] <= wd;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rspv) begin
      if (rspq.size() == 0) chk("unexpected_rspv", 32'd1, 32'd0);
      else begin
        mon_r = rspq.pop_front();
        chk("rsp1", 32'(rsp1), 32'(mon_r.r1));
        chk("rsp2", 32'(rsp2), 32'(mon_r.r2));
        chk("err", 32'(err), 32'(mon_r.e));
        chk("rsp_cycle", 32'(cyc), 32'(mon_r.cyc));
      end
    end
    if (we) begin
      if (wq.size() == 0) chk("unexpected_we", 32'(wa), 32'hDEAD);
      else begin
        mon_w = wq.pop_front();
        chk("wa", 32'(wa), 32'(mon_w.a));
        chk("wd", 32'(wd), 32'(mon_w.d));
        chk("we_cycle", 32'(cyc), 32'(mon_w.cyc));
      end
    end
  end

  // Wait for acceptance; returns the index of the accepting clock edge, or -1.
  task automatic wait_accept(output int acc, output bit held);
    int waited;
    waited = 0;
    held = 1'b0;
    @(negedge clk);
    while (!reqr && waited < 100) begin
      held = 1'b1;
      waited++;
      @(negedge clk);
    end
    if (!reqr) begin
      chk("accept_timeout", 32'd0, 32'd1);
      acc = -1;
    end else begin
      acc = cyc + 1;
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [3:0] aa, input logic [3:0] bb,
                       input logic [WIDTH-1:0] dd);
    int acc, lat;
    bit held, e;
    rsp_t r;
    wr_t w;
    logic [WIDTH-1:0] v;
    op = o; a = aa; b = bb; d = dd; reqv = 1'b1;
    wait_accept(acc, held);
    if (acc < 0) begin
      reqv = 1'b0;
      return;
    end
    if (held && prev_valid) chk("throughput_accept", 32'(acc), 32'(prev_acc + prev_lat + 1));
    e = ((o != 2'b11) && (int'(aa) >= DEPTH)) ||
        (((o == 2'b00) || (o == 2'b10)) && (int'(bb) >= DEPTH));
    r.r1 = '0; r.r2 = '0; r.e = e;
    if (e) lat = 1;
    else begin
      case (o)
        2'b00: begin
          r.r1 = model[aa];
          r.r2 = model[bb];
          lat = 2;
        end
        2'b01: begin
          model[aa] = dd;
          r.r1 = dd;
          w.a = aa; w.d = dd; w.cyc = acc;
          wq.push_back(w);
          lat = 2;
        end
        2'b10: begin
          v = model[bb];
          model[aa] = v;
          r.r1 = v;
          w.a = aa; w.d = v; w.cyc = acc + 1;
          wq.push_back(w);
          lat = 3;
        end
        default: begin
          for (int i = 0; i < DEPTH; i++) begin
            model[i] = '0;
            w.a = 4'(i); w.d = '0; w.cyc = acc + i;
            wq.push_back(w);
          end
          lat = DEPTH + 1;
        end
      endcase
    end
    r.cyc = acc + lat - 1;
    rspq.push_back(r);
    prev_acc = acc; prev_lat = lat; prev_valid = 1'b1;
    @(posedge clk); #1;
    reqv = 1'b0;
  endtask

  task automatic clear_with_reset_abort();
    int acc;
    bit held;
    wr_t w;
    op = 2'b11; a = 4'd0; b = 4'd0; d = '0; reqv = 1'b1;
    wait_accept(acc, held);
    if (acc < 0) begin
      reqv = 1'b0;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      model[i] = '0;
      w.a = 4'(i); w.d = '0; w.cyc = acc + i;
      wq.push_back(w);
    end
    @(posedge clk); #1;
    reqv = 1'b0;
    while (cyc < acc + 4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    prev_valid = 1'b0;
    @(negedge clk);
    chk("abort_reqr", 32'(reqr), 32'd1);
    chk("abort_we", 32'(we), 32'd0);
    chk("abort_rspv", 32'(rspv), 32'd0);
    chk("abort_rsp1", 32'(rsp1), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic fill_all();
    for (int i = 0; i < DEPTH; i++) issue(2'b01, 4'(i), 4'd0, WIDTH'($urandom));
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) issue(2'b00, 4'(i), 4'(DEPTH - 1 - i), '0);
  endtask

  initial begin
    logic [WIDTH-1:0] v;
    int k, r, g;
    logic [1:0] o;
    logic [3:0] ra, rb;
    for (int i = 0; i < 16; i++) begin
      v = WIDTH'($urandom);
      ram[i] <= v;
      if (i < DEPTH) model[i] = v;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_reqr", 32'(reqr), 32'd1);
    chk("reset_rspv", 32'(rspv), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_we", 32'(we), 32'd0);
    chk("reset_rsp1", 32'(rsp1), 32'd0);
    chk("reset_rsp2", 32'(rsp2), 32'd0);
    chk("reset_ra1", 32'(ra1), 32'd0);
    chk("reset_ra2", 32'(ra2), 32'd0);
    chk("reset_wa", 32'(wa), 32'd0);
    chk("reset_wd", 32'(wd), 32'd0);
    @(posedge clk); #1;

    issue(2'b11, 4'd0, 4'd0, '0);
    issue(2'b01, 4'd3, 4'd0, 15'h1ABC);
    issue(2'b00, 4'd3, 4'd0, '0);
    issue(2'b01, 4'd2, 4'd0, 15'h7FFF);
    issue(2'b10, 4'd9, 4'd2, '0);
    issue(2'b00, 4'd9, 4'd2, '0);
    issue(2'b01, 4'd10, 4'd0, 15'h1234);
    issue(2'b00, 4'd0, 4'd15, '0);
    issue(2'b10, 4'd15, 4'd1, '0);
    issue(2'b00, 4'd3, 4'd2, '0);
    issue(2'b10, 4'd5, 4'd5, '0);
    issue(2'b00, 4'd5, 4'd9, '0);
    fill_all();
    issue(2'b11, 4'd0, 4'd0, '0);
    read_all();
    fill_all();
    clear_with_reset_abort();
    read_all();

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 15);
      o = (r < 5) ? 2'b00 : (r < 10) ? 2'b01 : (r < 14) ? 2'b10 : 2'b11;
      ra = 4'($urandom_range(0, 12));
      rb = 4'($urandom_range(0, 12));
      if (ra == 4'd12) ra = 4'd15;
      if (rb == 4'd12) rb = 4'd15;
      issue(o, ra, rb, WIDTH'($urandom));
      g = $urandom_range(0, 3);
      if (g == 3) begin
        repeat ($urandom_range(1, 4)) begin
          @(posedge clk); #1;
        end
      end
    end

    k = 0;
    while ((rspq.size() != 0 || wq.size() != 0) && k < 60) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1;
    chk("pending_rsp", 32'(rspq.size()), 32'd0);
    chk("pending_wr", 32'(wq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
